// File: rtl/memory_bank_pkg.sv
// Shared types and helpers for the banked memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state_t (IDLE / CLEAR) for the clear sequencer, and safe_clog2,
// a $clog2 that never returns less than 1 so every index field has at least one bit.
package memory_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memory_bank_array.sv
// One memory bank: DEPTH words x BIT_SIZE bits.
// Latency: write lands on the clock edge; read data is registered one cycle after rd_en.
// Backpressure: none; the read register holds its value while rd_en is low.
//
// Ports: clk; wr_en/wr_addr/wr_data (synchronous write);
//        rd_en/rd_addr -> rd_data (synchronous read, read-first against a same-edge write).
// Neither the storage nor the read register has a reset. The parent masks rd_data until a read has loaded it.
module memory_bank_array
    import memory_bank_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BIT_SIZE = 16,
    parameter int ADDR_W   = safe_clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BIT_SIZE-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [BIT_SIZE-1:0] rd_data
);

    logic [BIT_SIZE-1:0] mem [DEPTH];

    // Both assignments are non-blocking. A read and a write to the same word
    // on the same edge therefore return the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_bank.sv
// NUM_BANKS independent banks with one write port (optional broadcast), one read port, and a clear sequencer.
// Latency: a read accepted in cycle N presents rd_data_valid/rd_data in cycle N+1.
// Backpressure: rd_req_ready drops while busy, or while a word is held and rd_data_ready is low.
//
// Ports: clk, rst_n (async active-low); clear/busy (zeroing sequence);
//        wr_en, wr_broadcast, wr_bank, wr_addr, wr_data (write);
//        rd_req_valid/rd_req_ready, rd_bank, rd_addr (read request);
//        rd_data_valid/rd_data_ready, rd_data (read response).
// Build option MEMORY_BANK_BYPASS_EN:
//   - defined: a same-cycle write to the word being read forwards wr_data (write-first).
//   - undefined: the read returns the old contents (read-first).
module memory_bank
    import memory_bank_pkg::*;
#(
    parameter  int NUM_BANKS = 4,
    parameter  int DEPTH     = 16,
    parameter  int BIT_SIZE  = 16,
    localparam int BANK_W    = safe_clog2(NUM_BANKS),
    localparam int ADDR_W    = safe_clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    output logic                busy,
    input  logic                wr_en,
    input  logic                wr_broadcast,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BIT_SIZE-1:0] wr_data,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_data_valid,
    input  logic                rd_data_ready,
    output logic [BIT_SIZE-1:0] rd_data
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic                clr_last;

    logic                wr_ok;
    logic                rd_ok;
    logic                rd_acc;
    logic [ADDR_W-1:0]   arr_wr_addr;
    logic [BIT_SIZE-1:0] arr_wr_data;

    logic                rd_hit;   // the held word came from an in-range location
    logic [BANK_W-1:0]   rd_sel;   // bank that produced the held word
    logic [BIT_SIZE-1:0] rd_mem;
    logic [BIT_SIZE-1:0] bank_rd [NUM_BANKS];

    // ---------------- clear sequencer ----------------
    assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                // A clear pulse in this state is ignored. The sequence always runs exactly DEPTH cycles.
                if (clr_last) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy         = (state == CLEAR);
    assign rd_req_ready = !busy && (!rd_data_valid || rd_data_ready);
    assign rd_acc       = rd_req_valid && rd_req_ready;

    // ---------------- decode ----------------
    // The fields are widened before the range compare. This keeps the test
    // meaningful when NUM_BANKS or DEPTH is not a power of two.
    assign wr_ok = wr_en && !busy && (32'(wr_addr) < DEPTH)
                   && (wr_broadcast || (32'(wr_bank) < NUM_BANKS));
    assign rd_ok = (32'(rd_bank) < NUM_BANKS) && (32'(rd_addr) < DEPTH);

    // While clearing, the sequencer owns the write port of every bank.
    assign arr_wr_addr = busy ? clr_cnt : wr_addr;
    assign arr_wr_data = busy ? '0 : wr_data;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic we;
        assign we = busy || (wr_ok && (wr_broadcast || (wr_bank == BANK_W'(g))));

        memory_bank_array #(
            .DEPTH    (DEPTH),
            .BIT_SIZE (BIT_SIZE),
            .ADDR_W   (ADDR_W)
        ) u_array (
            .clk     (clk),
            .wr_en   (we),
            .wr_addr (arr_wr_addr),
            .wr_data (arr_wr_data),
            .rd_en   (rd_acc),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[g])
        );
    end

    // ---------------- state and handshake registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            rd_data_valid <= 1'b0;
            rd_hit        <= 1'b0;
            rd_sel        <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            if (rd_acc) begin
                rd_data_valid <= 1'b1;
                rd_hit        <= rd_ok;
                rd_sel        <= rd_bank;
            end else if (rd_data_ready) begin
                rd_data_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mem = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_sel == BANK_W'(b)) begin
                rd_mem = bank_rd[b];
            end
        end
    end

`ifdef MEMORY_BANK_BYPASS_EN
    logic                byp;
    logic [BIT_SIZE-1:0] byp_dat;

    // Captured only on acceptance. A held word therefore keeps its forwarded value until it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp     <= 1'b0;
            byp_dat <= '0;
        end else if (rd_acc) begin
            byp     <= rd_ok && wr_ok && (wr_addr == rd_addr)
                       && (wr_broadcast || (wr_bank == rd_bank));
            byp_dat <= wr_data;
        end
    end

    assign rd_data = byp ? byp_dat : (rd_hit ? rd_mem : '0);
`else
    assign rd_data = rd_hit ? rd_mem : '0;
`endif

endmodule

// File: tb/tb_memory_bank.sv
module tb_memory_bank;

`ifdef MEMORY_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        busy;
    logic        wr_en;
    logic        wr_broadcast;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [1:0]  rd_bank;
    logic [3:0]  rd_addr;
    logic        rd_data_valid;
    logic        rd_data_ready;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    memory_bank #(
        .NUM_BANKS (4),
        .DEPTH     (16),
        .BIT_SIZE  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .busy          (busy),
        .wr_en         (wr_en),
        .wr_broadcast  (wr_broadcast),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          op;     // 0 write, 1 broadcast write, 2 read
        logic [1:0]  bank;
        logic [3:0]  addr;
        logic [15:0] dat;    // write data, or expected read data
        string       nm;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // All tasks start and end on a falling clock edge.
    task automatic do_write(input logic [1:0] b, input logic [3:0] a, input logic [15:0] d, input logic bc);
        wr_en        = 1'b1;
        wr_broadcast = bc;
        wr_bank      = b;
        wr_addr      = a;
        wr_data      = d;
        @(negedge clk);
        wr_en        = 1'b0;
        wr_broadcast = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] b, input logic [3:0] a, input logic [15:0] exp, input string nm);
        rd_req_valid  = 1'b1;
        rd_bank       = b;
        rd_addr       = a;
        rd_data_ready = 1'b1;
        @(negedge clk);
        rd_req_valid  = 1'b0;
        check(nm, {15'b0, rd_data_valid, rd_data}, {15'b0, 1'b1, exp});
    endtask

    task automatic sweep(input string nm);
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 16; a++) begin
                do_read(2'(b), 4'(a), 16'h0000, nm);
            end
        end
    endtask

    // Counts the cycles in which busy is high. When inject is set, it also pulses clear
    // at cycle 4 and attempts a write (bank 0, address 1) at cycle 14.
    task automatic run_clear(input bit inject, output int n, output int rdy_seen);
        n        = 0;
        rdy_seen = 0;
        while (busy === 1'b1 && n < 100) begin
            clear = inject && (n == 4);
            if (inject && n == 14) begin
                wr_en   = 1'b1;
                wr_bank = 2'd0;
                wr_addr = 4'd1;
                wr_data = 16'h7777;
            end else begin
                wr_en = 1'b0;
            end
            if (rd_req_ready !== 1'b0) rdy_seen = 1;
            n++;
            @(negedge clk);
        end
        clear = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int n;
        int r;

        vecs[0]  = '{0, 2'd2, 4'd5,  16'hBEEF, "wr_b2a5"};
        vecs[1]  = '{2, 2'd2, 4'd5,  16'hBEEF, "rd_b2a5"};
        vecs[2]  = '{2, 2'd1, 4'd5,  16'h0000, "rd_b1a5_untouched"};
        vecs[3]  = '{1, 2'd0, 4'd3,  16'h1234, "bc_a3"};
        vecs[4]  = '{2, 2'd0, 4'd3,  16'h1234, "rd_bc_b0"};
        vecs[5]  = '{2, 2'd1, 4'd3,  16'h1234, "rd_bc_b1"};
        vecs[6]  = '{2, 2'd2, 4'd3,  16'h1234, "rd_bc_b2"};
        vecs[7]  = '{2, 2'd3, 4'd3,  16'h1234, "rd_bc_b3"};
        vecs[8]  = '{0, 2'd3, 4'd15, 16'hFFFF, "wr_b3a15"};
        vecs[9]  = '{2, 2'd3, 4'd15, 16'hFFFF, "rd_b3a15_corner"};
        vecs[10] = '{2, 2'd3, 4'd14, 16'h0000, "rd_b3a14_neighbor"};
        vecs[11] = '{0, 2'd1, 4'd7,  16'h5555, "wr_b1a7"};
        vecs[12] = '{2, 2'd1, 4'd7,  16'h5555, "rd_b1a7"};

        rst_n = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_broadcast = 1'b0;
        wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b0; rd_bank = '0; rd_addr = '0; rd_data_ready = 1'b1;

        // ---- reset values and power-up clear ----
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",          32'(busy),          32'd1);
        check("rst_rd_req_ready",  32'(rd_req_ready),  32'd0);
        check("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        check("rst_rd_data",       32'(rd_data),       32'd0);
        rst_n = 1'b1;
        run_clear(1'b0, n, r);
        check("t1_busy_cycles",    32'(n), 32'd16);
        check("t1_ready_in_clear", 32'(r), 32'd0);
        sweep("t1_sweep_zero");

        // ---- directed write/read table ----
        for (int i = 0; i < 13; i++) begin
            case (vecs[i].op)
                0: do_write(vecs[i].bank, vecs[i].addr, vecs[i].dat, 1'b0);
                1: do_write(vecs[i].bank, vecs[i].addr, vecs[i].dat, 1'b1);
                default: do_read(vecs[i].bank, vecs[i].addr, vecs[i].dat, vecs[i].nm);
            endcase
        end

        // ---- streaming reads with a stall ----
        for (int a = 8; a < 16; a++) do_write(2'd0, 4'(a), 16'(32'h1000 + a), 1'b0);
        @(negedge clk);
        rd_req_valid  = 1'b1;
        rd_bank       = 2'd0;
        rd_addr       = 4'd8;
        rd_data_ready = 1'b0;
        @(negedge clk);
        check("t4_first", {15'b0, rd_data_valid, rd_data}, {15'b0, 1'b1, 16'h1008});
        rd_addr = 4'd9;
        repeat (3) begin
            @(negedge clk);
            check("t4_hold", {15'b0, rd_req_ready, rd_data}, {15'b0, 1'b0, 16'h1008});
        end
        rd_data_ready = 1'b1;
        for (int i = 9; i < 16; i++) begin
            @(negedge clk);
            check("t4_stream", {15'b0, rd_data_valid, rd_data}, {15'b0, 1'b1, 16'(32'h1000 + i)});
            if (i < 15) rd_addr = 4'(i + 1);
            else        rd_req_valid = 1'b0;
        end

        // ---- same-cycle read and write ----
        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 4'd7; wr_data = 16'hAAAA;
        rd_req_valid = 1'b1; rd_bank = 2'd1; rd_addr = 4'd7;
        @(negedge clk);
        wr_en = 1'b0; rd_req_valid = 1'b0;
        check("t5_same_cycle", {15'b0, rd_data_valid, rd_data},
              {15'b0, 1'b1, (BYP ? 16'hAAAA : 16'h5555)});
        do_read(2'd1, 4'd7, 16'hAAAA, "t5_later");

        wr_en = 1'b1; wr_broadcast = 1'b1; wr_bank = 2'd0; wr_addr = 4'd3; wr_data = 16'h4321;
        rd_req_valid = 1'b1; rd_bank = 2'd2; rd_addr = 4'd3;
        @(negedge clk);
        wr_en = 1'b0; wr_broadcast = 1'b0; rd_req_valid = 1'b0;
        check("t5_same_cycle_bc", 32'(rd_data), 32'(BYP ? 16'h4321 : 16'h1234));
        do_read(2'd2, 4'd3, 16'h4321, "t5_bc_later");

        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 4'd6; wr_data = 16'h6666;
        rd_req_valid = 1'b1; rd_bank = 2'd1; rd_addr = 4'd7;
        @(negedge clk);
        wr_en = 1'b0; rd_req_valid = 1'b0;
        check("t5_diff_addr", 32'(rd_data), 32'h0000AAAA);
        do_read(2'd1, 4'd6, 16'h6666, "t5_diff_later");

        // ---- requested clear: re-pulse ignored, writes dropped ----
        clear = 1'b1;
        @(negedge clk);
        run_clear(1'b1, n, r);
        check("tc_busy_cycles",    32'(n), 32'd16);
        check("tc_ready_in_clear", 32'(r), 32'd0);
        do_read(2'd0, 4'd1, 16'h0000, "tc_write_dropped");
        do_read(2'd0, 4'd8, 16'h0000, "tc_zeroed_b0a8");
        do_read(2'd1, 4'd7, 16'h0000, "tc_zeroed_b1a7");

        // ---- reset during clear with a held read word ----
        do_write(2'd0, 4'd3, 16'h1234, 1'b0);
        rd_req_valid  = 1'b1;
        rd_bank       = 2'd0;
        rd_addr       = 4'd3;
        rd_data_ready = 1'b0;
        @(negedge clk);
        rd_req_valid = 1'b0;
        clear        = 1'b1;
        check("t6_pending", {15'b0, rd_data_valid, rd_data}, {15'b0, 1'b1, 16'h1234});
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            clear = (k == 4);
            if (k == 2) check("t6_held_in_clear", {15'b0, rd_data_valid, rd_data}, {15'b0, 1'b1, 16'h1234});
            @(negedge clk);
        end
        clear = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",          32'(busy),          32'd1);
        check("t6_rst_rd_req_ready",  32'(rd_req_ready),  32'd0);
        check("t6_rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        check("t6_rst_rd_data",       32'(rd_data),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        rd_data_ready = 1'b1;
        run_clear(1'b0, n, r);
        check("t6_busy_cycles", 32'(n), 32'd16);
        sweep("t6_sweep_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
